// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL field widths, opcodes and packed beat layouts for the
// channel buffer and its queues.
package tl_ul_pkg;

  localparam int unsigned A_OPCODE_W = 3;
  localparam int unsigned A_SIZE_W   = 4;
  localparam int unsigned A_ADDR_W   = 32;
  localparam int unsigned A_MASK_W   = 8;
  localparam int unsigned A_DATA_W   = 64;
  localparam int unsigned D_PARAM_W  = 2;
  localparam int unsigned D_SINK_W   = 3;

  localparam int unsigned A_W = 111;
  localparam int unsigned D_W = 78;

  localparam logic [2:0] A_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] A_GET              = 3'd4;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [A_OPCODE_W-1:0] opcode;
    logic [A_SIZE_W-1:0]   size;
    logic [A_ADDR_W-1:0]   address;
    logic [A_MASK_W-1:0]   mask;
    logic [A_DATA_W-1:0]   data;
  } a_beat_t;

  typedef struct packed {
    logic [A_OPCODE_W-1:0] opcode;
    logic [D_PARAM_W-1:0]  param;
    logic [A_SIZE_W-1:0]   size;
    logic [D_SINK_W-1:0]   sink;
    logic                  denied;
    logic [A_DATA_W-1:0]   data;
    logic                  corrupt;
  } d_beat_t;

endpackage

// File: rtl/tl_queue.sv
// Parameterised-depth FIFO with optional same-cycle flow-through; DEPTH=0
// degenerates to a plain wire.
module tl_queue #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2,
  parameter bit          FLOW  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  output logic             enq_ready,
  input  logic             enq_valid,
  input  logic [WIDTH-1:0] enq_bits,
  input  logic             deq_ready,
  output logic             deq_valid,
  output logic [WIDTH-1:0] deq_bits
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign enq_ready = deq_ready;
      assign deq_valid = enq_valid;
      assign deq_bits  = enq_bits;
    end else begin : g_q
      localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

      logic [WIDTH-1:0] mem_r [DEPTH];
      logic [PW-1:0]    enq_ptr_r;
      logic [PW-1:0]    deq_ptr_r;
      logic             maybe_full_r;
      logic             empty_s;
      logic             full_s;
      logic             bypass_s;
      logic             do_enq_s;
      logic             do_deq_s;

      function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
          return '0;
        end else begin
          return p + PW'(1);
        end
      endfunction

      // Occupancy flags and fire qualification; a bypassed beat neither stores nor pops.
      always_comb begin
        empty_s   = (enq_ptr_r == deq_ptr_r) && !maybe_full_r;
        full_s    = (enq_ptr_r == deq_ptr_r) && maybe_full_r;
        bypass_s  = FLOW && empty_s;
        enq_ready = !full_s;
        deq_valid = !empty_s || (FLOW && enq_valid);
        do_enq_s  = enq_valid && enq_ready && !(bypass_s && deq_ready);
        do_deq_s  = deq_valid && deq_ready && !bypass_s;
        if (bypass_s) begin
          deq_bits = enq_bits;
        end else begin
          deq_bits = mem_r[deq_ptr_r];
        end
      end

      // Payload storage, deliberately left out of reset.
      always_ff @(posedge clock) begin
        if (do_enq_s) begin
          mem_r[enq_ptr_r] <= enq_bits;
        end
      end

      // Pointer and maybe_full bookkeeping.
      always_ff @(posedge clock) begin
        if (reset) begin
          enq_ptr_r    <= '0;
          deq_ptr_r    <= '0;
          maybe_full_r <= 1'b0;
        end else begin
          if (do_enq_s) begin
            enq_ptr_r <= next_ptr(enq_ptr_r);
          end
          if (do_deq_s) begin
            deq_ptr_r <= next_ptr(deq_ptr_r);
          end
          if (do_enq_s != do_deq_s) begin
            maybe_full_r <= do_enq_s;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/tl_ul_buffer.sv
// TileLink-UL channel buffer: one independent FIFO on the A channel and one on
// the D channel, fields passed through untouched.
module tl_ul_buffer
  import tl_ul_pkg::*;
#(
  parameter int unsigned A_DEPTH = 2,
  parameter int unsigned D_DEPTH = 2,
  parameter bit          A_FLOW  = 1'b0,
  parameter bit          D_FLOW  = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [3:0]  auto_in_a_bits_size,
  input  logic [31:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [3:0]  auto_in_d_bits_size,
  output logic [2:0]  auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt,
  input  logic        auto_out_a_ready,
  output logic        auto_out_a_valid,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [3:0]  auto_out_a_bits_size,
  output logic [31:0] auto_out_a_bits_address,
  output logic [7:0]  auto_out_a_bits_mask,
  output logic [63:0] auto_out_a_bits_data,
  output logic        auto_out_d_ready,
  input  logic        auto_out_d_valid,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [1:0]  auto_out_d_bits_param,
  input  logic [3:0]  auto_out_d_bits_size,
  input  logic [2:0]  auto_out_d_bits_sink,
  input  logic        auto_out_d_bits_denied,
  input  logic [63:0] auto_out_d_bits_data,
  input  logic        auto_out_d_bits_corrupt
);

  a_beat_t a_enq_s;
  a_beat_t a_deq_s;
  d_beat_t d_enq_s;
  d_beat_t d_deq_s;

  assign a_enq_s = '{opcode:  auto_in_a_bits_opcode,
                     size:    auto_in_a_bits_size,
                     address: auto_in_a_bits_address,
                     mask:    auto_in_a_bits_mask,
                     data:    auto_in_a_bits_data};

  assign d_enq_s = '{opcode:  auto_out_d_bits_opcode,
                     param:   auto_out_d_bits_param,
                     size:    auto_out_d_bits_size,
                     sink:    auto_out_d_bits_sink,
                     denied:  auto_out_d_bits_denied,
                     data:    auto_out_d_bits_data,
                     corrupt: auto_out_d_bits_corrupt};

  tl_queue #(.WIDTH(A_W), .DEPTH(A_DEPTH), .FLOW(A_FLOW)) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_ready (auto_in_a_ready),
    .enq_valid (auto_in_a_valid),
    .enq_bits  (a_enq_s),
    .deq_ready (auto_out_a_ready),
    .deq_valid (auto_out_a_valid),
    .deq_bits  (a_deq_s)
  );

  // D flows slave-to-master, so its enqueue side is the out port.
  tl_queue #(.WIDTH(D_W), .DEPTH(D_DEPTH), .FLOW(D_FLOW)) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_ready (auto_out_d_ready),
    .enq_valid (auto_out_d_valid),
    .enq_bits  (d_enq_s),
    .deq_ready (auto_in_d_ready),
    .deq_valid (auto_in_d_valid),
    .deq_bits  (d_deq_s)
  );

  assign auto_out_a_bits_opcode  = a_deq_s.opcode;
  assign auto_out_a_bits_size    = a_deq_s.size;
  assign auto_out_a_bits_address = a_deq_s.address;
  assign auto_out_a_bits_mask    = a_deq_s.mask;
  assign auto_out_a_bits_data    = a_deq_s.data;

  assign auto_in_d_bits_opcode  = d_deq_s.opcode;
  assign auto_in_d_bits_param   = d_deq_s.param;
  assign auto_in_d_bits_size    = d_deq_s.size;
  assign auto_in_d_bits_sink    = d_deq_s.sink;
  assign auto_in_d_bits_denied  = d_deq_s.denied;
  assign auto_in_d_bits_data    = d_deq_s.data;
  assign auto_in_d_bits_corrupt = d_deq_s.corrupt;

endmodule

// File: tb/tb_tl_ul_buffer.sv
// Directed and randomised self-checking bench for tl_ul_buffer: a 2-deep
// instance with D flow-through and a 3-deep instance for scoreboard traffic.
module tb_tl_ul_buffer;

  logic clock = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // A word: opcode[110:108] size[107:104] address[103:72] mask[71:64] data[63:0]
  // D word: opcode[77:75] param[74:73] size[72:69] sink[68:66] denied[65] data[64:1] corrupt[0]
  logic         in_a_valid, out_a_ready, out_d_valid, in_d_ready;
  logic [110:0] in_a_word;
  logic [77:0]  out_d_word;
  wire          in_a_ready, out_a_valid, out_d_ready, in_d_valid;
  wire  [110:0] out_a_word;
  wire  [77:0]  in_d_word;

  logic         r_in_a_valid, r_out_a_ready, r_out_d_valid, r_in_d_ready;
  logic [110:0] r_in_a_word;
  logic [77:0]  r_out_d_word;
  wire          r_in_a_ready, r_out_a_valid, r_out_d_ready, r_in_d_valid;
  wire  [110:0] r_out_a_word;
  wire  [77:0]  r_in_d_word;

  tl_ul_buffer #(.A_DEPTH(2), .D_DEPTH(2), .A_FLOW(1'b0), .D_FLOW(1'b1)) dut (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(in_a_ready), .auto_in_a_valid(in_a_valid),
    .auto_in_a_bits_opcode(in_a_word[110:108]), .auto_in_a_bits_size(in_a_word[107:104]),
    .auto_in_a_bits_address(in_a_word[103:72]), .auto_in_a_bits_mask(in_a_word[71:64]),
    .auto_in_a_bits_data(in_a_word[63:0]),
    .auto_in_d_ready(in_d_ready), .auto_in_d_valid(in_d_valid),
    .auto_in_d_bits_opcode(in_d_word[77:75]), .auto_in_d_bits_param(in_d_word[74:73]),
    .auto_in_d_bits_size(in_d_word[72:69]), .auto_in_d_bits_sink(in_d_word[68:66]),
    .auto_in_d_bits_denied(in_d_word[65]), .auto_in_d_bits_data(in_d_word[64:1]),
    .auto_in_d_bits_corrupt(in_d_word[0]),
    .auto_out_a_ready(out_a_ready), .auto_out_a_valid(out_a_valid),
    .auto_out_a_bits_opcode(out_a_word[110:108]), .auto_out_a_bits_size(out_a_word[107:104]),
    .auto_out_a_bits_address(out_a_word[103:72]), .auto_out_a_bits_mask(out_a_word[71:64]),
    .auto_out_a_bits_data(out_a_word[63:0]),
    .auto_out_d_ready(out_d_ready), .auto_out_d_valid(out_d_valid),
    .auto_out_d_bits_opcode(out_d_word[77:75]), .auto_out_d_bits_param(out_d_word[74:73]),
    .auto_out_d_bits_size(out_d_word[72:69]), .auto_out_d_bits_sink(out_d_word[68:66]),
    .auto_out_d_bits_denied(out_d_word[65]), .auto_out_d_bits_data(out_d_word[64:1]),
    .auto_out_d_bits_corrupt(out_d_word[0])
  );

  tl_ul_buffer #(.A_DEPTH(3), .D_DEPTH(3), .A_FLOW(1'b0), .D_FLOW(1'b0)) dut3 (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(r_in_a_ready), .auto_in_a_valid(r_in_a_valid),
    .auto_in_a_bits_opcode(r_in_a_word[110:108]), .auto_in_a_bits_size(r_in_a_word[107:104]),
    .auto_in_a_bits_address(r_in_a_word[103:72]), .auto_in_a_bits_mask(r_in_a_word[71:64]),
    .auto_in_a_bits_data(r_in_a_word[63:0]),
    .auto_in_d_ready(r_in_d_ready), .auto_in_d_valid(r_in_d_valid),
    .auto_in_d_bits_opcode(r_in_d_word[77:75]), .auto_in_d_bits_param(r_in_d_word[74:73]),
    .auto_in_d_bits_size(r_in_d_word[72:69]), .auto_in_d_bits_sink(r_in_d_word[68:66]),
    .auto_in_d_bits_denied(r_in_d_word[65]), .auto_in_d_bits_data(r_in_d_word[64:1]),
    .auto_in_d_bits_corrupt(r_in_d_word[0]),
    .auto_out_a_ready(r_out_a_ready), .auto_out_a_valid(r_out_a_valid),
    .auto_out_a_bits_opcode(r_out_a_word[110:108]), .auto_out_a_bits_size(r_out_a_word[107:104]),
    .auto_out_a_bits_address(r_out_a_word[103:72]), .auto_out_a_bits_mask(r_out_a_word[71:64]),
    .auto_out_a_bits_data(r_out_a_word[63:0]),
    .auto_out_d_ready(r_out_d_ready), .auto_out_d_valid(r_out_d_valid),
    .auto_out_d_bits_opcode(r_out_d_word[77:75]), .auto_out_d_bits_param(r_out_d_word[74:73]),
    .auto_out_d_bits_size(r_out_d_word[72:69]), .auto_out_d_bits_sink(r_out_d_word[68:66]),
    .auto_out_d_bits_denied(r_out_d_word[65]), .auto_out_d_bits_data(r_out_d_word[64:1]),
    .auto_out_d_bits_corrupt(r_out_d_word[0])
  );

  // Deterministic payloads derived from a sequence number for the scoreboard.
  function automatic logic [110:0] a_word_of(input logic [31:0] s);
    return {s[2:0], s[6:3], s ^ 32'h5A5A_0000, s[7:0] ^ 8'hA5, ~s, s};
  endfunction

  function automatic logic [77:0] d_word_of(input logic [31:0] s);
    return {s[2:0], s[4:3], s[8:5], s[11:9], s[12], s, ~s, s[13]};
  endfunction

  task automatic idle_inputs();
    in_a_valid = 1'b0; out_a_ready = 1'b0; out_d_valid = 1'b0; in_d_ready = 1'b0;
    in_a_word = '0; out_d_word = '0;
    r_in_a_valid = 1'b0; r_out_a_ready = 1'b0; r_out_d_valid = 1'b0; r_in_d_ready = 1'b0;
    r_in_a_word = '0; r_out_d_word = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (out_a_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_a_valid: got %b expected 0", out_a_valid);
    end
    checks++;
    if (in_d_valid !== 1'b0) begin
      errors++; $display("FAIL reset_in_d_valid: got %b expected 0", in_d_valid);
    end
    checks++;
    if (in_a_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_a_ready: got %b expected 1", in_a_ready);
    end
    checks++;
    if (out_d_ready !== 1'b1) begin
      errors++; $display("FAIL reset_out_d_ready: got %b expected 1", out_d_ready);
    end
  endtask

  task automatic test_single_get();
    logic [110:0] beat;
    beat = {3'd4, 4'd3, 32'h8000_0000, 8'hFF, 64'h0};
    @(negedge clock);
    in_a_valid = 1'b1; in_a_word = beat; out_a_ready = 1'b1;
    #1;
    checks++;
    if (out_a_valid !== 1'b0) begin
      errors++; $display("FAIL get_latency0: out_a_valid got %b expected 0", out_a_valid);
    end
    @(negedge clock);
    in_a_valid = 1'b0; in_a_word = '0;
    #1;
    checks++;
    if (out_a_valid !== 1'b1 || out_a_word !== beat) begin
      errors++; $display("FAIL get_latency1: valid %b word %h expected 1 %h", out_a_valid, out_a_word, beat);
    end
    @(negedge clock);
    #1;
    checks++;
    if (out_a_valid !== 1'b0) begin
      errors++; $display("FAIL get_drained: out_a_valid got %b expected 0", out_a_valid);
    end
  endtask

  task automatic test_fill();
    logic [110:0] b [3];
    logic [110:0] got [3];
    int n;
    bit sent;
    b[0] = {3'd0, 4'd3, 32'h1000_0000, 8'hFF, 64'h1111_2222_3333_4444};
    b[1] = {3'd1, 4'd2, 32'h1000_0008, 8'h0F, 64'h5555_6666_7777_8888};
    b[2] = {3'd4, 4'd3, 32'h1000_0010, 8'hF0, 64'h9999_AAAA_BBBB_CCCC};
    out_a_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      in_a_valid = 1'b1; in_a_word = b[k];
      #1;
      checks++;
      if (in_a_ready !== (k < 2)) begin
        errors++; $display("FAIL fill_ready_%0d: got %b expected %b", k, in_a_ready, (k < 2));
      end
    end
    checks++;
    if (out_a_valid !== 1'b1 || out_a_word !== b[0]) begin
      errors++; $display("FAIL fill_head_held: valid %b word %h expected 1 %h", out_a_valid, out_a_word, b[0]);
    end
    n = 0; sent = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      out_a_ready = 1'b1;
      if (sent) in_a_valid = 1'b0;
      #1;
      if (out_a_valid) begin
        if (n < 3) got[n] = out_a_word;
        n++;
      end
      if (in_a_valid && in_a_ready) sent = 1'b1;
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL fill_count: got %0d beats expected 3", n);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (n > k && got[k] !== b[k]) begin
        errors++; $display("FAIL fill_order_%0d: got %h expected %h", k, got[k], b[k]);
      end
    end
    out_a_ready = 1'b0; in_a_valid = 1'b0;
  endtask

  task automatic test_full_deq();
    logic [110:0] c [3];
    c[0] = {3'd0, 4'd2, 32'h2000_0000, 8'h01, 64'hA0A0_A0A0_A0A0_A0A0};
    c[1] = {3'd0, 4'd2, 32'h2000_0004, 8'h02, 64'hB1B1_B1B1_B1B1_B1B1};
    c[2] = {3'd1, 4'd2, 32'h2000_0008, 8'h04, 64'hC2C2_C2C2_C2C2_C2C2};
    out_a_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      in_a_valid = 1'b1; in_a_word = c[k];
    end
    @(negedge clock);
    in_a_word = c[2]; out_a_ready = 1'b1;
    #1;
    checks++;
    if (in_a_ready !== 1'b0 || out_a_word !== c[0] || out_a_valid !== 1'b1) begin
      errors++; $display("FAIL full_deq_refuse: ready %b out %h expected 0 %h", in_a_ready, out_a_word, c[0]);
    end
    @(negedge clock);
    #1;
    checks++;
    if (in_a_ready !== 1'b1 || out_a_word !== c[1] || out_a_valid !== 1'b1) begin
      errors++; $display("FAIL full_deq_accept: ready %b out %h expected 1 %h", in_a_ready, out_a_word, c[1]);
    end
    @(negedge clock);
    in_a_valid = 1'b0;
    #1;
    checks++;
    if (out_a_valid !== 1'b1 || out_a_word !== c[2]) begin
      errors++; $display("FAIL full_deq_third: valid %b out %h expected 1 %h", out_a_valid, out_a_word, c[2]);
    end
    @(negedge clock);
    #1;
    checks++;
    if (out_a_valid !== 1'b0) begin
      errors++; $display("FAIL full_deq_nodup: out_a_valid got %b expected 0", out_a_valid);
    end
    out_a_ready = 1'b0;
  endtask

  task automatic test_d_flow();
    logic [77:0] ack_data;
    logic [77:0] ack;
    ack_data = {3'd1, 2'd0, 4'd3, 3'd0, 1'b0, 64'hDEAD_BEEF_0123_4567, 1'b1};
    ack      = {3'd0, 2'd0, 4'd2, 3'd5, 1'b1, 64'h0, 1'b0};
    @(negedge clock);
    in_d_ready = 1'b1; out_d_valid = 1'b1; out_d_word = ack_data;
    #1;
    checks++;
    if (in_d_valid !== 1'b1 || in_d_word !== ack_data) begin
      errors++; $display("FAIL dflow_same_cycle: valid %b word %h expected 1 %h", in_d_valid, in_d_word, ack_data);
    end
    checks++;
    if (out_d_ready !== 1'b1) begin
      errors++; $display("FAIL dflow_ready: got %b expected 1", out_d_ready);
    end
    @(negedge clock);
    out_d_valid = 1'b0;
    #1;
    checks++;
    if (in_d_valid !== 1'b0) begin
      errors++; $display("FAIL dflow_not_stored: in_d_valid got %b expected 0", in_d_valid);
    end
    @(negedge clock);
    in_d_ready = 1'b0; out_d_valid = 1'b1; out_d_word = ack;
    #1;
    checks++;
    if (in_d_valid !== 1'b1 || in_d_word !== ack) begin
      errors++; $display("FAIL dflow_stall_bypass: valid %b word %h expected 1 %h", in_d_valid, in_d_word, ack);
    end
    @(negedge clock);
    out_d_valid = 1'b0; out_d_word = '0; in_d_ready = 1'b1;
    #1;
    checks++;
    if (in_d_valid !== 1'b1 || in_d_word !== ack) begin
      errors++; $display("FAIL dflow_stored: valid %b word %h expected 1 %h", in_d_valid, in_d_word, ack);
    end
    @(negedge clock);
    #1;
    checks++;
    if (in_d_valid !== 1'b0) begin
      errors++; $display("FAIL dflow_drained: in_d_valid got %b expected 0", in_d_valid);
    end
    in_d_ready = 1'b0;
  endtask

  task automatic test_random();
    int unsigned a_sb [$];
    int unsigned d_sb [$];
    int unsigned a_seq, d_seq;
    int a_out, d_out, cyc;
    bit a_sent, d_sent, a_prev_v, d_prev_v;
    logic [110:0] a_prev_w;
    logic [77:0]  d_prev_w;
    a_seq = 32'd1; d_seq = 32'd1; a_out = 0; d_out = 0; cyc = 0;
    a_sent = 1'b0; d_sent = 1'b0; a_prev_v = 1'b0; d_prev_v = 1'b0;
    a_prev_w = '0; d_prev_w = '0;
    while ((a_out < 10000 || d_out < 10000) && cyc < 70000) begin
      @(negedge clock);
      cyc++;
      if (cyc == 12000) begin
        reset = 1'b1;
        r_in_a_valid = 1'b0; r_out_d_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        r_out_a_ready = 1'b0; r_in_d_ready = 1'b0;
        #1;
        checks++;
        if (r_out_a_valid !== 1'b0 || r_in_d_valid !== 1'b0 || r_in_a_ready !== 1'b1 || r_out_d_ready !== 1'b1) begin
          errors++; $display("FAIL rand_midreset: out_a_valid %b in_d_valid %b in_a_ready %b out_d_ready %b expected 0 0 1 1",
                             r_out_a_valid, r_in_d_valid, r_in_a_ready, r_out_d_ready);
        end
        a_sb.delete(); d_sb.delete();
        a_sent = 1'b0; d_sent = 1'b0; a_prev_v = 1'b0; d_prev_v = 1'b0;
        continue;
      end
      if (a_sent) r_in_a_valid = 1'b0;
      if (d_sent) r_out_d_valid = 1'b0;
      a_sent = 1'b0; d_sent = 1'b0;
      if (!r_in_a_valid && $urandom_range(1) == 1) begin
        r_in_a_valid = 1'b1; r_in_a_word = a_word_of(a_seq);
      end
      if (!r_out_d_valid && $urandom_range(1) == 1) begin
        r_out_d_valid = 1'b1; r_out_d_word = d_word_of(d_seq);
      end
      r_out_a_ready = ($urandom_range(1) == 1);
      r_in_d_ready  = ($urandom_range(1) == 1);
      #1;
      if (a_prev_v) begin
        checks++;
        if (r_out_a_valid !== 1'b1 || r_out_a_word !== a_prev_w) begin
          errors++; $display("FAIL rand_a_stable: valid %b word %h expected 1 %h", r_out_a_valid, r_out_a_word, a_prev_w);
        end
      end
      if (d_prev_v) begin
        checks++;
        if (r_in_d_valid !== 1'b1 || r_in_d_word !== d_prev_w) begin
          errors++; $display("FAIL rand_d_stable: valid %b word %h expected 1 %h", r_in_d_valid, r_in_d_word, d_prev_w);
        end
      end
      if (r_out_a_valid && r_out_a_ready) begin
        checks++;
        if (a_sb.size() == 0) begin
          errors++; $display("FAIL rand_a_order: got %h expected no beat", r_out_a_word);
        end else begin
          if (r_out_a_word !== a_word_of(a_sb[0])) begin
            errors++; $display("FAIL rand_a_order: got %h expected %h", r_out_a_word, a_word_of(a_sb[0]));
          end
          void'(a_sb.pop_front());
        end
        a_out++;
      end
      if (r_in_d_valid && r_in_d_ready) begin
        checks++;
        if (d_sb.size() == 0) begin
          errors++; $display("FAIL rand_d_order: got %h expected no beat", r_in_d_word);
        end else begin
          if (r_in_d_word !== d_word_of(d_sb[0])) begin
            errors++; $display("FAIL rand_d_order: got %h expected %h", r_in_d_word, d_word_of(d_sb[0]));
          end
          void'(d_sb.pop_front());
        end
        d_out++;
      end
      a_prev_v = r_out_a_valid && !r_out_a_ready; a_prev_w = r_out_a_word;
      d_prev_v = r_in_d_valid && !r_in_d_ready;   d_prev_w = r_in_d_word;
      if (r_in_a_valid && r_in_a_ready) begin
        a_sb.push_back(a_seq); a_seq++; a_sent = 1'b1;
      end
      if (r_out_d_valid && r_out_d_ready) begin
        d_sb.push_back(d_seq); d_seq++; d_sent = 1'b1;
      end
    end
    checks++;
    if (a_out < 10000 || d_out < 10000) begin
      errors++; $display("FAIL rand_progress: a beats %0d d beats %0d expected >= 10000 each", a_out, d_out);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_get();
    test_fill();
    test_full_deq();
    test_d_flow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
